uart_mmio_bridge: RTL

Memory-mapped front end between the pipelined MIPS core's data-memory port and the `UART` byte engine. It buffers CPU writes in a TX FIFO and drains them into the UART one byte at a time. It captures received bytes from the UART into an RX FIFO and raises a level interrupt toward the CPU. The UART itself is untouched; this block drives its `UART_TXD`/`TX_EN`/`RX_READ` inputs and consumes its `UART_RXD`/`RX_EFF`/`TX_STATUS` outputs.

---
 rtl/uart_mmio_bridge.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_bridge.sv
`default_nettype none
// ============================================================================
// uart_mmio_bridge : MMIO front end (TXD/RXD/CON) between CPU data port and UART.
// Define UART_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise a 1-byte holding register.
// Revision: 1.0
// ============================================================================
module uart_mmio_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h40000018,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  UART_TXD,
    output logic        TX_EN,
    input  logic        TX_STATUS,
    input  logic [7:0]  UART_RXD,
    input  logic        RX_EFF,
    output logic        RX_READ
);

    localparam int TX_AW = $clog2(TX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_SEND      = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_IDLE = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_WAIT = 2'd0,
        RX_ACK  = 2'd1,
        RX_DROP = 2'd2
    } rx_state_e;

    if ((TX_DEPTH < 2) || ((TX_DEPTH & (TX_DEPTH - 1)) != 0)) begin : g_bad_tx_depth
        $error("TX_DEPTH must be a power of two >= 2");
    end
    if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_rx_depth
        $error("RX_DEPTH must be a power of two >= 2");
    end

    tx_state_e      tx_state_q;
    rx_state_e      rx_state_q;
    logic [7:0]     uart_txd_q;
    logic           tx_en_q;
    logic           rx_read_q;
    logic           ovf_q;
    logic           rx_ie_q;
    logic           tx_ie_q;
    logic           irq_q;

    logic [7:0]     tx_mem_q [TX_DEPTH];
    logic [TX_AW:0] tx_wptr_q;
    logic [TX_AW:0] tx_rptr_q;

    logic           w_sel_txd;
    logic           w_sel_rxd;
    logic           w_sel_con;
    logic           w_tx_wr;
    logic           w_con_wr;
    logic           w_tx_empty;
    logic           w_tx_full;
    logic           w_tx_push;
    logic           w_tx_pop;
    logic [7:0]     w_tx_head;
    logic           w_rx_empty;
    logic           w_rx_full;
    logic           w_rx_push;
    logic           w_rx_pop;
    logic [7:0]     w_rx_head;
    logic           w_unused;

    assign w_sel_txd = (addr == BASE_ADDR);
    assign w_sel_rxd = (addr == BASE_ADDR + 32'd4);
    assign w_sel_con = (addr == BASE_ADDR + 32'd8);
    assign w_tx_wr   = MemWrite & w_sel_txd;
    assign w_con_wr  = MemWrite & w_sel_con;
    assign w_unused  = &{1'b0, wdata[31:8]};

    // Full/empty come from registered pointers only, so a drain pop never frees room for a same-cycle push.
    assign w_tx_empty = (tx_wptr_q == tx_rptr_q);
    assign w_tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                        (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
    assign w_tx_head  = tx_mem_q[tx_rptr_q[TX_AW-1:0]];
    assign w_tx_push  = w_tx_wr & ~w_tx_full;
    assign w_tx_pop   = (tx_state_q == TX_IDLE) & ~w_tx_empty & TX_STATUS;

    assign w_rx_push  = (rx_state_q == RX_WAIT) & RX_EFF & ~w_rx_full;
    assign w_rx_pop   = MemRead & w_sel_rxd & ~w_rx_empty;

    always_ff @(posedge sysclk) begin
        if (w_tx_push) begin
            tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= wdata[7:0];
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            if (w_tx_push) begin
                tx_wptr_q <= tx_wptr_q + 1'b1;
            end
            if (w_tx_pop) begin
                tx_rptr_q <= tx_rptr_q + 1'b1;
            end
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int RX_AW = $clog2(RX_DEPTH);

    logic [7:0]     rx_mem_q [RX_DEPTH];
    logic [RX_AW:0] rx_wptr_q;
    logic [RX_AW:0] rx_rptr_q;

    assign w_rx_empty = (rx_wptr_q == rx_rptr_q);
    assign w_rx_full  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                        (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
    assign w_rx_head  = rx_mem_q[rx_rptr_q[RX_AW-1:0]];

    always_ff @(posedge sysclk) begin
        if (w_rx_push) begin
            rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= UART_RXD;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (w_rx_push) begin
                rx_wptr_q <= rx_wptr_q + 1'b1;
            end
            if (w_rx_pop) begin
                rx_rptr_q <= rx_rptr_q + 1'b1;
            end
        end
    end
`else
    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    assign w_rx_empty = ~rx_valid_q;
    assign w_rx_full  = rx_valid_q;
    assign w_rx_head  = rx_data_q;

    always_ff @(posedge sysclk) begin
        if (w_rx_push) begin
            rx_data_q <= UART_RXD;
        end
    end

    // Push needs an empty holder and pop needs a full one, so they never coincide.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
        end else if (w_rx_push) begin
            rx_valid_q <= 1'b1;
        end else if (w_rx_pop) begin
            rx_valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            uart_txd_q <= '0;
            tx_en_q    <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (w_tx_pop) begin
                        uart_txd_q <= w_tx_head;
                        tx_state_q <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    tx_en_q    <= 1'b1;
                    tx_state_q <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (!TX_STATUS) begin
                        tx_state_q <= TX_WAIT_IDLE;
                    end
                end
                TX_WAIT_IDLE: begin
                    if (TX_STATUS) begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // DROP holds off re-capture until the UART has withdrawn the byte it was acknowledged for.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_state_q <= RX_WAIT;
            rx_read_q  <= 1'b0;
        end else begin
            rx_read_q <= 1'b0;
            case (rx_state_q)
                RX_WAIT: begin
                    if (w_rx_push) begin
                        rx_read_q  <= 1'b1;
                        rx_state_q <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    rx_state_q <= RX_DROP;
                end
                RX_DROP: begin
                    if (!RX_EFF) begin
                        rx_state_q <= RX_WAIT;
                    end
                end
                default: rx_state_q <= RX_WAIT;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            rx_ie_q <= 1'b0;
            tx_ie_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (w_tx_wr && w_tx_full) begin
                ovf_q <= 1'b1;
            end else if (w_con_wr && wdata[3]) begin
                ovf_q <= 1'b0;
            end
            if (w_con_wr) begin
                rx_ie_q <= wdata[4];
                tx_ie_q <= wdata[5];
            end
            irq_q <= (rx_ie_q & ~w_rx_empty) |
                     (tx_ie_q & w_tx_empty & (tx_state_q == TX_IDLE));
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (w_sel_rxd) begin
            rdata = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
        end else if (w_sel_con) begin
            rdata = {26'd0, tx_ie_q, rx_ie_q, ovf_q, w_rx_empty, w_tx_empty, w_tx_full};
        end
    end

    assign irq      = irq_q;
    assign UART_TXD = uart_txd_q;
    assign TX_EN    = tx_en_q;
    assign RX_READ  = rx_read_q;

endmodule
`default_nettype wire
